// File: rtl/mmc1_serial_writer.sv
// rtl/mmc1_serial_writer.sv - serialises a 5-bit MMC1 register value into five LSB-first CPU writes
// Optional MMC1_SW_PRESYNC_EN: prefix each transaction with a $80 shift-register reset write.
module mmc1_serial_writer #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_reg,
    input  logic [4:0]  req_data,
    output logic [15:0] cpu_addr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_write,
    output logic        busy,
    output logic        done
);

`ifdef MMC1_SW_PRESYNC_EN
    typedef enum logic [2:0] {IDLE, SYNC, WRITE, GAP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, GAP, DONE} state_t;
`endif

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_nxt;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]  reg_q, reg_d;
    logic [4:0]  data_q, data_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        write_q, write_d;
    logic        done_q, done_d;
`ifdef MMC1_SW_PRESYNC_EN
    logic        first_q, first_d;
`endif

    assign bit_nxt = bit_cnt_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        reg_d     = reg_q;
        data_d    = data_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        write_d   = 1'b0;
        done_d    = 1'b0;
`ifdef MMC1_SW_PRESYNC_EN
        first_d   = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    reg_d     = req_reg;
                    data_d    = req_data;
                    bit_cnt_d = 3'd0;
                    write_d   = 1'b1;
`ifdef MMC1_SW_PRESYNC_EN
                    state_d   = SYNC;
                    addr_d    = 16'h8000;
                    dout_d    = 8'h80;
                    first_d   = 1'b1;
`else
                    state_d   = WRITE;
                    addr_d    = {1'b1, req_reg, 13'h0000};
                    dout_d    = {7'b0, req_data[0]};
`endif
                end
            end
`ifdef MMC1_SW_PRESYNC_EN
            SYNC: begin
                state_d   = GAP;
                gap_cnt_d = GAP_LAST;
            end
`endif
            WRITE: begin
                state_d   = GAP;
                gap_cnt_d = GAP_LAST;
            end
            GAP: begin
                if (gap_cnt_q != 4'd0) begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
`ifdef MMC1_SW_PRESYNC_EN
                end else if (first_q) begin
                    // Gap after the sync write leads into data bit 0.
                    first_d = 1'b0;
                    state_d = WRITE;
                    write_d = 1'b1;
                    addr_d  = {1'b1, reg_q, 13'h0000};
                    dout_d  = {7'b0, data_q[0]};
`endif
                end else if (bit_cnt_q == 3'd4) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    bit_cnt_d = bit_nxt;
                    state_d   = WRITE;
                    write_d   = 1'b1;
                    addr_d    = {1'b1, reg_q, 13'h0000};
                    dout_d    = {7'b0, data_q[bit_nxt]};
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            gap_cnt_q <= 4'd0;
            reg_q     <= 2'd0;
            data_q    <= 5'd0;
            addr_q    <= 16'h0000;
            dout_q    <= 8'h00;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef MMC1_SW_PRESYNC_EN
            first_q   <= 1'b0;
`endif
        end else if (ce) begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            write_q   <= write_d;
            done_q    <= done_d;
`ifdef MMC1_SW_PRESYNC_EN
            first_q   <= first_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cpu_addr  = addr_q;
    assign cpu_dout  = dout_q;
    assign cpu_write = write_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// tb/tb_mmc1_serial_writer.sv - scoreboard bench for mmc1_serial_writer with an MMC1 shift-register model
module tb_mmc1_serial_writer;
`ifdef MMC1_SW_PRESYNC_EN
    localparam bit PRESYNC = 1'b1;
`else
    localparam bit PRESYNC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, ce, req_valid, sel;
    logic [1:0]  req_reg;
    logic [4:0]  req_data;
    logic        rdy1, wr1, busy1, done1, rdy3, wr3, busy3, done3;
    logic [15:0] addr1, addr3;
    logic [7:0]  dout1, dout3;
    logic        m_ready, m_write, m_busy, m_done;
    logic [15:0] m_addr;
    logic [7:0]  m_dout;

    mmc1_serial_writer #(.GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .req_valid(req_valid & ~sel), .req_ready(rdy1),
        .req_reg(req_reg), .req_data(req_data), .cpu_addr(addr1), .cpu_dout(dout1),
        .cpu_write(wr1), .busy(busy1), .done(done1)
    );

    mmc1_serial_writer #(.GAP_CYCLES(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .req_valid(req_valid & sel), .req_ready(rdy3),
        .req_reg(req_reg), .req_data(req_data), .cpu_addr(addr3), .cpu_dout(dout3),
        .cpu_write(wr3), .busy(busy3), .done(done3)
    );

    assign m_ready = sel ? rdy3  : rdy1;
    assign m_write = sel ? wr3   : wr1;
    assign m_busy  = sel ? busy3 : busy1;
    assign m_done  = sel ? done3 : done1;
    assign m_addr  = sel ? addr3 : addr1;
    assign m_dout  = sel ? dout3 : dout1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dout;
        int          off;
    } exp_t;

    exp_t wq[$];
    int   dq[$];
    int   checks = 0, failures = 0;
    int   tick = 0, cyc = 0, t_acc = 0, acc_cnt = 0, wr_cnt = 0;
    int   last_wr = -10, last_done = 0, ce_mode = 0;
    bit   in_txn = 1'b0, s_ready = 1'b0;
    logic [4:0] mmc_shift = 5'd0, mmc_prg = 5'd0;
    int   mmc_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clk; observations are made only after ticks, for the value the next tick will see.
    task automatic step();
        bit   e_ce, e_rst, e_acc;
        int   wt;
        exp_t e;
        @(posedge clk);
        e_ce  = ce;
        e_rst = reset_n;
        e_acc = ce && reset_n && req_valid && s_ready;
        @(negedge clk);
        cyc++;
        if (e_rst && e_ce) begin
            tick++;
            if (e_acc) begin
                t_acc  = tick;
                in_txn = 1'b1;
                acc_cnt++;
            end
            if (m_write) begin
                wt = tick + 1;
                chk("write_not_adjacent", 32'(wt == last_wr + 1), 32'd0);
                last_wr = wt;
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = wq.pop_front();
                    chk("write_addr", 32'(m_addr), 32'(e.addr));
                    chk("write_dout", 32'(m_dout), 32'(e.dout));
                    chk("write_tick", 32'(wt - t_acc), 32'(e.off));
                end
                wr_cnt++;
                if (m_dout[7]) begin
                    mmc_shift = 5'd0;
                    mmc_cnt   = 0;
                end else begin
                    mmc_shift = {m_dout[0], mmc_shift[4:1]};
                    mmc_cnt++;
                    if (mmc_cnt == 5) begin
                        if (m_addr[14:13] == 2'd3) mmc_prg = mmc_shift;
                        mmc_shift = 5'd0;
                        mmc_cnt   = 0;
                    end
                end
            end
            chk("busy", 32'(m_busy), 32'(in_txn));
            chk("req_ready", 32'(m_ready), 32'(!in_txn));
            if (m_done) begin
                if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("done_tick", 32'(tick + 1 - t_acc), 32'(dq.pop_front()));
                last_done = tick + 1;
                in_txn    = 1'b0;
            end
        end
        s_ready = m_ready;
        ce = (ce_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    endtask

    task automatic push_txn(input logic [1:0] r, input logic [4:0] d, input int g);
        int   sh;
        exp_t e;
        sh = PRESYNC ? (1 + g) : 0;
        if (PRESYNC) begin
            e = '{16'h8000, 8'h80, 1};
            wq.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            e = '{{1'b1, r, 13'h0000}, {7'b0, d[k]}, sh + 1 + k * (1 + g)};
            wq.push_back(e);
        end
        dq.push_back(sh + 1 + 5 * (1 + g));
    endtask

    task automatic wait_accept(input int n, input string tag);
        int b = 0;
        while (acc_cnt < n && b < 300) begin
            step();
            b++;
        end
        chk(tag, 32'(acc_cnt >= n), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int b = 0;
        while ((wq.size() != 0 || dq.size() != 0 || in_txn) && b < 600) begin
            step();
            b++;
        end
        chk(tag, 32'(b < 600), 32'd1);
        step();
    endtask

    task automatic run_txn(input logic [1:0] r, input logic [4:0] d, input int g, input string tag);
        req_reg  = r;
        req_data = d;
        push_txn(r, d, g);
        req_valid = 1'b1;
        wait_accept(acc_cnt + 1, {tag, "_accept"});
        req_valid = 1'b0;
        wait_drain({tag, "_drain"});
    endtask

    initial begin
        int base, t1, sh1;
        sel = 1'b0; ce = 1'b1; req_valid = 1'b0; req_reg = 2'd0; req_data = 5'd0;
        reset_n = 1'b0;
        sh1 = PRESYNC ? 1 : 0;
        step();
        step();
        chk("rst_cpu_write", 32'(wr1), 32'd0);
        chk("rst_cpu_addr", 32'(addr1), 32'h0000);
        chk("rst_cpu_dout", 32'(dout1), 32'h00);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_busy_gap3", 32'(busy3), 32'd0);
        reset_n = 1'b1;
        step();
        chk("ready_after_reset", 32'(rdy1), 32'd1);

        // reg 3 = 01101 with ce always high
        base = wr_cnt;
        run_txn(2'd3, 5'b01101, 1, "t1");
        chk("t1_done_offset", 32'(last_done - t_acc), PRESYNC ? 32'd13 : 32'd11);
        chk("t1_write_count", 32'(wr_cnt - base), 32'(5 + sh1));

        // reg 0 = 11111 with ce high one clock in three
        ce_mode = 1;
        base = wr_cnt;
        run_txn(2'd0, 5'b11111, 1, "t2");
        chk("t2_write_count", 32'(wr_cnt - base), 32'(5 + sh1));
        ce_mode = 0;
        step();

        // back-to-back with req_valid held
        base = wr_cnt;
        req_reg = 2'd1; req_data = 5'h0A;
        push_txn(2'd1, 5'h0A, 1);
        push_txn(2'd2, 5'h15, 1);
        req_valid = 1'b1;
        wait_accept(acc_cnt + 1, "b2b_first_accept");
        t1 = acc_cnt;
        req_reg = 2'd2; req_data = 5'h15;
        wait_accept(t1 + 1, "b2b_second_accept");
        chk("b2b_accept_after_done", 32'(t_acc), 32'(last_done + 1));
        req_valid = 1'b0;
        wait_drain("b2b_drain");
        chk("b2b_write_count", 32'(wr_cnt - base), 32'(10 + 2 * sh1));

        // reset right after write 2
        base = wr_cnt;
        req_reg = 2'd3; req_data = 5'h1B;
        push_txn(2'd3, 5'h1B, 1);
        req_valid = 1'b1;
        wait_accept(acc_cnt + 1, "mid_accept");
        req_valid = 1'b0;
        t1 = 0;
        while (wr_cnt < base + 3 + sh1 && t1 < 100) begin
            step();
            t1++;
        end
        chk("mid_reach_write2", 32'(wr_cnt), 32'(base + 3 + sh1));
        step();
        reset_n = 1'b0;
        step();
        chk("mid_rst_cpu_write", 32'(wr1), 32'd0);
        chk("mid_rst_busy", 32'(busy1), 32'd0);
        chk("mid_rst_done", 32'(done1), 32'd0);
        reset_n = 1'b1;
        wq.delete();
        dq.delete();
        in_txn = 1'b0;
        for (int i = 0; i < 20; i++) step();
        run_txn(2'd1, 5'h05, 1, "after_reset");

        // mapper loopback with two stray bits already shifted in
        mmc_shift = 5'd0;
        mmc_cnt   = 2;
        mmc_prg   = 5'h1F;
        run_txn(2'd3, 5'h0D, 1, "loopback");
        chk("loopback_prg", 32'(mmc_prg), PRESYNC ? 32'h0D : 32'h14);

        // GAP_CYCLES = 3 instance
        sel = 1'b1;
        step();
        run_txn(2'd2, 5'b10000, 3, "gap3");
        chk("gap3_done_offset", 32'(last_done - t_acc), PRESYNC ? 32'd25 : 32'd21);
        sel = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmc1_serial_writer.md
MMC1_SERIAL_WRITER -- requirements
Module: mmc1_serial_writer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, meaning the number of idle ce ticks with cpu_write low after each write (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; the block has one clock and all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset; it is synchronous and active-low.
REQ-004 SHALL have port ce, input, 1, the CPU clock enable; the FSM advances only on clk edges with ce=1 ("ticks").
REQ-005 SHALL have port req_valid, input, 1, the request strobe.
REQ-006 SHALL have port req_ready, output, 1, high only in IDLE.
REQ-007 SHALL have port req_reg, input, 2, the MMC1 register index (0 control, 1 chr0, 2 chr1, 3 prg).
REQ-008 SHALL have port req_data, input, 5, the register value.
REQ-009 SHALL have port cpu_addr, output, 16, the emitted CPU write address.
REQ-010 SHALL have port cpu_dout, output, 8, the emitted CPU write data.
REQ-011 SHALL have port cpu_write, output, 1, the CPU write strobe.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-013 SHALL have port done, output, 1, a one-tick completion pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, SYNC, WRITE, GAP and DONE.
REQ-015 SHALL accept a request on a tick in IDLE with req_valid=1, latching req_reg and req_data; no fields are sampled afterwards.
REQ-016 SHALL emit the latched value as 5 writes, LSB first: write k drives cpu_dout={7'b0, data[k]} and cpu_addr={1'b1, reg, 13'h0000}.
REQ-017 SHALL hold cpu_write high for exactly one tick per write (the WRITE state), followed by GAP_CYCLES ticks with cpu_write=0 (the GAP state).
REQ-018 SHALL use a 3-bit bit counter (0..4); after the GAP that follows write 4, the FSM enters DONE for one tick and then returns to IDLE.
REQ-019 SHALL, without the presync feature, give this timing for a request accepted at tick T: write k at tick T+1+k*(1+GAP_CYCLES), done at tick T+1+5*(1+GAP_CYCLES), req_ready high again the tick after done.
REQ-020 SHALL, with GAP_CYCLES=1 and no presync, place the writes at T+1/3/5/7/9 and done at T+11.
REQ-021 SHALL freeze all outputs and state when ce=0; cpu_write may stay high across ce-low clocks.
REQ-022 SHALL hold cpu_addr and cpu_dout at their last values while cpu_write=0.
REQ-023 SHALL not accept a new request while in DONE.
REQ-024 SHALL, when req_valid is held continuously, accept the next request at the tick after DONE, with no overlap between transactions.
REQ-025 SHALL treat GAP_CYCLES=0 as illegal, because two writes without an intervening cpu_write-low tick are ignored by the mapper.

Reset
REQ-026 SHALL, with reset_n=0 on any clk edge (ce is ignored), set: state IDLE, cpu_write 0, cpu_addr 16'h0000, cpu_dout 8'h00, busy 0, done 0, bit counter 0, gap counter 0.
REQ-027 SHALL make req_ready high on the first edge after reset is released.
REQ-028 SHALL, when reset is asserted mid-transaction, abandon the partial sequence with no completion pulse; the mapper shift register may be left desynchronised.

Configuration
REQ-029 SHALL, when macro MMC1_SW_PRESYNC_EN is defined, begin every transaction with a SYNC write (cpu_addr 16'h8000, cpu_dout 8'h80, one tick) plus GAP_CYCLES gap ticks before data write 0, shifting every later tick by 1+GAP_CYCLES (GAP=1: sync at T+1, data writes at T+3..T+11, done at T+13).
REQ-030 SHALL, when MMC1_SW_PRESYNC_EN is undefined, omit the SYNC state entirely, so each transaction is exactly 5 writes.

Verification
REQ-031 SHALL verify: ce=1 always, GAP=1, req_reg=3, req_data=5'b01101 -> writes at $E000 with data 01,00,01,01,00 at T+1/3/5/7/9, done at T+11, busy high T+1..T+11.
REQ-032 SHALL verify: req_reg=0, req_data=5'b11111, ce toggling 1-of-3 clocks -> same 5 writes at $8000, each cpu_write high for exactly one ce tick, ordering identical to ce=1.
REQ-033 SHALL verify: req_valid held high with req_reg=1/5'h0A then req_reg=2/5'h15 -> the second acceptance occurs the tick after the first done, giving 10 writes with no cpu_write-high on adjacent ticks.
REQ-034 SHALL verify: reset_n low for one clk right after write 2 -> next edge has cpu_write=0, busy=0, done never pulses, and a fresh request then runs from write 0.
REQ-035 SHALL verify: with MMC1_SW_PRESYNC_EN, a loopback into an MMC1 instance pre-loaded with 2 stray bit writes, then request reg 3 = 5'h0D -> the mapper prg_bank reads 5'h0D; the same stimulus without the macro leaves prg_bank not equal to 5'h0D.
REQ-036 SHALL verify: GAP_CYCLES=3, req_reg=2, req_data=5'b10000 -> writes at $C000 on T+1/5/9/13/17, data bit0 = 0,0,0,0,1, done at T+21.
